// File: rtl/ifetch_ir_stage.sv
// Instruction fetch / instruction-register stage: MFA/MOC memory handshake, IR hold until ack,
// PC redirect and sticky timeout. Define IFETCH_PREFETCH_EN to add a one-entry prefetch buffer.
module ifetch_ir_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] mem_addr,
    output logic        mem_mfa,
    input  logic        mem_moc,
    input  logic [31:0] mem_data,
    output logic [31:0] ir_out,
    output logic        ir_valid,
    input  logic        ir_ack,
    input  logic        br_load,
    input  logic [31:0] br_target,
    output logic [31:0] pc_out,
    output logic        fetch_err
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} fetchStateT;

    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT[7:0];

    fetchStateT  state, stateNxt;
    logic [31:0] pc, pcNxt;
    logic [31:0] irReg, irNxt;
    logic        irValid, irValidNxt;
    logic        fetchErr, errNxt;
    logic [7:0]  cnt, cntNxt;
    logic        brPend, pendNxt;
    logic [31:0] brTgt, tgtNxt;

    logic [31:0] brAddr;
    logic [31:0] pcInc;
    logic [7:0]  cntInc;
    logic        timeoutHit;

`ifdef IFETCH_PREFETCH_EN
    logic [31:0] pfBuf, pfBufNxt;
    logic        pfValid, pfValidNxt;
    logic        pfOut, pfOutNxt;
`endif

    // Wait counter sticks at the limit instead of wrapping.
    function automatic logic [7:0] satInc(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? v : v + 8'd1;
    endfunction

    assign brAddr     = br_target & ~32'h3;
    assign pcInc      = pc + 32'd4;
    assign cntInc     = satInc(cnt, TIMEOUT_LIM);
    assign timeoutHit = (cntInc >= TIMEOUT_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            irReg    <= '0;
            irValid  <= 1'b0;
            fetchErr <= 1'b0;
            cnt      <= '0;
            brPend   <= 1'b0;
            brTgt    <= '0;
`ifdef IFETCH_PREFETCH_EN
            pfBuf    <= '0;
            pfValid  <= 1'b0;
            pfOut    <= 1'b0;
`endif
        end else begin
            state    <= stateNxt;
            pc       <= pcNxt;
            irReg    <= irNxt;
            irValid  <= irValidNxt;
            fetchErr <= errNxt;
            cnt      <= cntNxt;
            brPend   <= pendNxt;
            brTgt    <= tgtNxt;
`ifdef IFETCH_PREFETCH_EN
            pfBuf    <= pfBufNxt;
            pfValid  <= pfValidNxt;
            pfOut    <= pfOutNxt;
`endif
        end
    end

    always_comb begin
        stateNxt   = state;
        pcNxt      = pc;
        irNxt      = irReg;
        irValidNxt = irValid;
        errNxt     = fetchErr;
        cntNxt     = cnt;
        pendNxt    = brPend;
        tgtNxt     = brTgt;
`ifdef IFETCH_PREFETCH_EN
        pfBufNxt   = pfBuf;
        pfValidNxt = pfValid;
        pfOutNxt   = pfOut;
`endif
        case (state)
            IDLE: begin
                if (br_load) begin
                    pcNxt      = brAddr;
                    irValidNxt = 1'b0;
                    stateNxt   = REQ;
                end else if (fetch_en) begin
                    stateNxt = REQ;
                end
            end
            REQ: begin
                cntNxt = '0;
                if (br_load) begin
                    pcNxt      = brAddr;
                    irValidNxt = 1'b0;
                end else begin
                    stateNxt = WAIT;
                end
            end
            WAIT: begin
                // The read in flight is never aborted; a redirect only decides where the data goes.
                if (mem_moc) begin
                    pendNxt = 1'b0;
                    if (br_load) begin
                        pcNxt    = brAddr;
                        stateNxt = REQ;
                    end else if (brPend) begin
                        pcNxt    = brTgt;
                        stateNxt = REQ;
                    end else begin
                        irNxt      = mem_data;
                        irValidNxt = 1'b1;
                        pcNxt      = pcInc;
                        stateNxt   = HOLD;
                    end
                end else begin
                    cntNxt = cntInc;
                    if (br_load) begin
                        pendNxt = 1'b1;
                        tgtNxt  = brAddr;
                    end
                    if (timeoutHit) begin
                        errNxt   = 1'b1;
                        pendNxt  = 1'b0;
                        stateNxt = ERR;
                    end
                end
            end
            HOLD: begin
`ifdef IFETCH_PREFETCH_EN
                if (br_load) begin
                    irValidNxt = 1'b0;
                    pfValidNxt = 1'b0;
                    pfOutNxt   = 1'b0;
                    if (pfOut && !mem_moc) begin
                        // Prefetch still outstanding: finish it in WAIT and discard the word.
                        pendNxt  = 1'b1;
                        tgtNxt   = brAddr;
                        cntNxt   = cntInc;
                        stateNxt = WAIT;
                        if (timeoutHit) begin
                            errNxt   = 1'b1;
                            pendNxt  = 1'b0;
                            stateNxt = ERR;
                        end
                    end else begin
                        pcNxt    = brAddr;
                        stateNxt = REQ;
                    end
                end else if (ir_ack) begin
                    if (pfValid) begin
                        irNxt      = pfBuf;
                        pfValidNxt = 1'b0;
                    end else if (pfOut && mem_moc) begin
                        irNxt    = mem_data;
                        pcNxt    = pcInc;
                        pfOutNxt = 1'b0;
                    end else if (pfOut) begin
                        // IR consumed before the prefetch returned; keep waiting on it as a normal fetch.
                        irValidNxt = 1'b0;
                        pfOutNxt   = 1'b0;
                        cntNxt     = cntInc;
                        stateNxt   = WAIT;
                        if (timeoutHit) begin
                            errNxt   = 1'b1;
                            stateNxt = ERR;
                        end
                    end else begin
                        irValidNxt = 1'b0;
                        stateNxt   = fetch_en ? REQ : IDLE;
                    end
                end else if (pfOut) begin
                    if (mem_moc) begin
                        pfBufNxt   = mem_data;
                        pfValidNxt = 1'b1;
                        pcNxt      = pcInc;
                        pfOutNxt   = 1'b0;
                    end else begin
                        cntNxt = cntInc;
                        if (timeoutHit) begin
                            errNxt     = 1'b1;
                            irValidNxt = 1'b0;
                            pfOutNxt   = 1'b0;
                            stateNxt   = ERR;
                        end
                    end
                end else if (!pfValid && fetch_en) begin
                    pfOutNxt = 1'b1;
                    cntNxt   = '0;
                end
`else
                if (br_load) begin
                    pcNxt      = brAddr;
                    irValidNxt = 1'b0;
                    stateNxt   = REQ;
                end else if (ir_ack) begin
                    irValidNxt = 1'b0;
                    stateNxt   = fetch_en ? REQ : IDLE;
                end
`endif
            end
            ERR: begin
                irValidNxt = 1'b0;
`ifdef IFETCH_PREFETCH_EN
                pfValidNxt = 1'b0;
                pfOutNxt   = 1'b0;
`endif
            end
            default: stateNxt = IDLE;
        endcase
    end

`ifdef IFETCH_PREFETCH_EN
    assign mem_mfa = (state == REQ) || (state == WAIT) || ((state == HOLD) && pfOut);
`else
    assign mem_mfa = (state == REQ) || (state == WAIT);
`endif
    assign mem_addr  = mem_mfa ? pc : '0;
    assign ir_out    = irReg;
    assign ir_valid  = irValid;
    assign pc_out    = pc;
    assign fetch_err = fetchErr;

endmodule

// File: tb/tb_ifetch_ir_stage.sv
// Directed bench for ifetch_ir_stage (default build): fetch, hold, branch, timeout, wrap, async reset.
module tb_ifetch_ir_stage;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] mem_addr;
    logic        mem_mfa;
    logic        mem_moc;
    logic [31:0] mem_data;
    logic [31:0] ir_out;
    logic        ir_valid;
    logic        ir_ack;
    logic        br_load;
    logic [31:0] br_target;
    logic [31:0] pc_out;
    logic        fetch_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] expQ[$];
    logic [31:0] words[4] = '{32'h052D56AD, 32'h04154275, 32'hE1D45004, 32'h01C000D0};
    logic [31:0] a;

    ifetch_ir_stage #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .mem_addr(mem_addr), .mem_mfa(mem_mfa), .mem_moc(mem_moc), .mem_data(mem_data),
        .ir_out(ir_out), .ir_valid(ir_valid), .ir_ack(ir_ack),
        .br_load(br_load), .br_target(br_target), .pc_out(pc_out), .fetch_err(fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for a request, then answer with mem_moc lat cycles after mem_mfa was first seen.
    task automatic memRead(input logic [31:0] word, input int lat, output logic [31:0] addr);
        int n = 0;
        while (mem_mfa !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("mfa_seen", {31'd0, mem_mfa}, 32'd1);
        addr = mem_addr;
        repeat (lat) tick();
        mem_moc  = 1'b1;
        mem_data = word;
        tick();
        mem_moc  = 1'b0;
        mem_data = '0;
    endtask

    task automatic expectIr(input string tag);
        int n = 0;
        logic [31:0] e;
        while (ir_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, {31'd0, ir_valid}, 32'd1);
        if (expQ.size() != 0) e = expQ.pop_front();
        else e = 32'hFFFF_FFFF;
        chk(tag, ir_out, e);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; mem_moc = 1'b0; mem_data = '0;
        ir_ack = 1'b0; br_load = 1'b0; br_target = '0;
        #2;
        chk("rst_pc",   pc_out, 32'h0);
        chk("rst_ir",   ir_out, 32'h0);
        chk("rst_vld",  {31'd0, ir_valid}, 32'd0);
        chk("rst_mfa",  {31'd0, mem_mfa}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_err",  {31'd0, fetch_err}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // single fetch and ack-to-request latency
        fetch_en = 1'b1;
        expQ.push_back(32'h0555E52B);
        memRead(32'h0555E52B, 1, a);
        chk("t1_addr", a, 32'h0);
        expectIr("t1_ir");
        chk("t1_pc", pc_out, 32'h4);
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        chk("t1_ack_mfa",  {31'd0, mem_mfa}, 32'd1);
        chk("t1_ack_addr", mem_addr, 32'h4);
        chk("t1_ack_vld",  {31'd0, ir_valid}, 32'd0);

        // four sequential fetches from reset, IR stable until ack
        doReset();
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(words[i]);
            memRead(words[i], 1 + (i % 2), a);
            chk($sformatf("t2_addr%0d", i), a, 32'(4 * i));
            expectIr($sformatf("t2_ir%0d", i));
            chk($sformatf("t2_pc%0d", i), pc_out, 32'(4 * (i + 1)));
            repeat (2) begin
                tick();
                chk($sformatf("t2_hold%0d", i), ir_out, words[i]);
                chk($sformatf("t2_holdv%0d", i), {31'd0, ir_valid}, 32'd1);
            end
            if (i < 3) begin
                ir_ack = 1'b1; tick(); ir_ack = 1'b0;
                chk($sformatf("t2_ackv%0d", i), {31'd0, ir_valid}, 32'd0);
            end
        end

        // branch in HOLD with misaligned target
        br_target = 32'h0000_0103; br_load = 1'b1; tick(); br_load = 1'b0;
        chk("t3_vld",  {31'd0, ir_valid}, 32'd0);
        chk("t3_mfa",  {31'd0, mem_mfa}, 32'd1);
        chk("t3_addr", mem_addr, 32'h100);
        chk("t3_pc",   pc_out, 32'h100);
        expQ.push_back(32'h13579BDF);
        memRead(32'h13579BDF, 1, a);
        chk("t3_raddr", a, 32'h100);
        expectIr("t3_ir");
        chk("t3_pc2", pc_out, 32'h104);
        fetch_en = 1'b0;
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        chk("t3_idle_mfa", {31'd0, mem_mfa}, 32'd0);
        tick();
        chk("t3_idle_mfa2", {31'd0, mem_mfa}, 32'd0);

        // branch during WAIT: in-flight word discarded
        fetch_en = 1'b1;
        tick();
        chk("t4_req_addr", mem_addr, 32'h104);
        tick();
        br_target = 32'h200; br_load = 1'b1; tick(); br_load = 1'b0;
        chk("t4_wait_mfa",  {31'd0, mem_mfa}, 32'd1);
        chk("t4_wait_addr", mem_addr, 32'h104);
        tick(); tick();
        mem_moc = 1'b1; mem_data = 32'hDEADBEEF; tick(); mem_moc = 1'b0; mem_data = '0;
        chk("t4_vld",  {31'd0, ir_valid}, 32'd0);
        chk("t4_ir",   ir_out, 32'h13579BDF);
        chk("t4_mfa",  {31'd0, mem_mfa}, 32'd1);
        chk("t4_addr", mem_addr, 32'h200);
        tick();
        br_target = 32'h300; br_load = 1'b1; mem_moc = 1'b1; mem_data = 32'h0BAD0BAD;
        tick();
        br_load = 1'b0; mem_moc = 1'b0; mem_data = '0;
        chk("t4_bm_vld",  {31'd0, ir_valid}, 32'd0);
        chk("t4_bm_ir",   ir_out, 32'h13579BDF);
        chk("t4_bm_addr", mem_addr, 32'h300);
        expQ.push_back(32'h2468ACE0);
        memRead(32'h2468ACE0, 1, a);
        chk("t4_raddr", a, 32'h300);
        expectIr("t4_ir2");
        chk("t4_pc", pc_out, 32'h304);
        br_target = 32'h400; br_load = 1'b1; ir_ack = 1'b1; tick();
        br_load = 1'b0; ir_ack = 1'b0;
        chk("t4_ba_vld",  {31'd0, ir_valid}, 32'd0);
        chk("t4_ba_addr", mem_addr, 32'h400);

        // memory timeout
        doReset();
        tick();
        chk("t5_req_mfa", {31'd0, mem_mfa}, 32'd1);
        tick();
        for (int k = 1; k < 15; k++) begin
            tick();
            chk($sformatf("t5_err_c%0d", k), {31'd0, fetch_err}, 32'd0);
            chk($sformatf("t5_mfa_c%0d", k), {31'd0, mem_mfa}, 32'd1);
        end
        tick();
        chk("t5_err",  {31'd0, fetch_err}, 32'd1);
        chk("t5_mfa",  {31'd0, mem_mfa}, 32'd0);
        chk("t5_addr", mem_addr, 32'h0);
        br_target = 32'h40; br_load = 1'b1; fetch_en = 1'b0; tick();
        fetch_en = 1'b1; tick();
        br_load = 1'b0;
        chk("t5_err_hold", {31'd0, fetch_err}, 32'd1);
        chk("t5_mfa_hold", {31'd0, mem_mfa}, 32'd0);
        chk("t5_pc_hold",  pc_out, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("t5_async_err", {31'd0, fetch_err}, 32'd0);
        fetch_en = 1'b0;
        tick();
        rst_n = 1'b1;

        // PC wrap and async reset during WAIT
        br_target = 32'hFFFF_FFFE; br_load = 1'b1; tick(); br_load = 1'b0;
        chk("t6_addr", mem_addr, 32'hFFFF_FFFC);
        expQ.push_back(32'h600DF00D);
        memRead(32'h600DF00D, 1, a);
        chk("t6_raddr", a, 32'hFFFF_FFFC);
        expectIr("t6_ir");
        chk("t6_pc_wrap", pc_out, 32'h0);
        fetch_en = 1'b1;
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        chk("t6_req_addr", mem_addr, 32'h0);
        tick();
        chk("t6_wait_mfa", {31'd0, mem_mfa}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_mfa", {31'd0, mem_mfa}, 32'd0);
        chk("t6_async_vld", {31'd0, ir_valid}, 32'd0);
        chk("t6_async_pc",  pc_out, 32'h0);
        tick();
        rst_n = 1'b1;

        chk("sb_drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifetch_ir_stage.md
Name: ifetch_ir_stage

Overview:
Instruction fetch and instruction-register stage that feeds the instruction encoder.
- Reads 32-bit words from instruction memory over an MFA/MOC request/complete handshake.
- Holds the fetched word in the IR and drives it to the encoder input.
- Advances the PC and stalls until the control unit acknowledges the IR.
- Supports PC redirection (branch) and a memory-timeout error.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 15, max cycles spent in WAIT without mem_moc before error (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  allow new fetches; 0 parks the stage in IDLE after the current IR is consumed
mem_addr  out  32  word address to instruction memory (= PC while requesting)
mem_mfa  out  1  memory function activate (read request)
mem_moc  in  1  memory operation complete; mem_data valid in the same cycle
mem_data  in  32  instruction word from memory
ir_out  out  32  instruction register contents, drives encoder input
ir_valid  out  1  ir_out holds an unconsumed instruction
ir_ack  in  1  control unit consumed ir_out (sampled only when ir_valid=1)
br_load  in  1  redirect PC
br_target  in  32  new PC; bits [1:0] forced to 0
pc_out  out  32  current PC (address of next fetch)
fetch_err  out  1  sticky memory-timeout flag

Behaviour:
Reset (async, rst_n=0):
- pc=RESET_PC, ir_out=0, ir_valid=0, mem_mfa=0, mem_addr=0, fetch_err=0.
- Timeout counter=0, pending-branch flag=0, state=IDLE.

FSM states: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: if fetch_en=1, go to REQ next cycle.
- REQ: one cycle. mem_mfa=1, mem_addr=pc, counter cleared. Then WAIT.
- WAIT: mem_mfa held 1, mem_addr stable.
  - On mem_moc=1, capture mem_data into ir_out, set ir_valid=1, pc<=pc+4, mem_mfa=0, go to HOLD.
  - Otherwise the counter increments. When it reaches TIMEOUT, set fetch_err=1, mem_mfa=0, go to ERR.
- HOLD: ir_out and ir_valid held stable.
  - On ir_ack=1: ir_valid<=0; go to REQ if fetch_en=1, else IDLE.
- ERR: terminal; mem_mfa=0, ir_valid=0. Exits only via rst_n.

Latency:
- REQ to IR is 1 cycle + memory wait.
- Best case mem_moc in the first WAIT cycle gives ir_valid 2 cycles after REQ entry.
- ack to next mem_mfa is 1 cycle.

Branch:
- br_load in IDLE/REQ/HOLD: pc<=br_target&~3, ir_valid<=0 (flush), next state REQ. Bus contents are irrelevant in these states.
- br_load in WAIT: the in-flight read is not aborted.
  - Store the target and set the pending flag.
  - On mem_moc, discard mem_data (ir unchanged, ir_valid stays 0), pc<=stored target, go to REQ.
  - A second br_load while pending overwrites the stored target.
- br_load and ir_ack in the same cycle: the branch wins; the IR is flushed, not delivered.
- br_load and mem_moc in the same WAIT cycle: the branch wins; the word is discarded and pc<=br_target.
- br_load in ERR: ignored.

Arithmetic:
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- The counter is 8 bits, saturating at TIMEOUT.

fetch_en:
- Deasserting fetch_en never aborts an in-flight WAIT or drops a held IR; it only prevents the next REQ.

Async reset mid-WAIT:
- Returns everything to reset values immediately; mem_mfa drops asynchronously.

Optional Feature:
IFETCH_PREFETCH_EN
- Defined: adds a one-entry prefetch buffer.
  - While in HOLD, the stage issues the next read at pc.
  - The returned word is held in the buffer with its own valid bit; pc advances.
  - On ir_ack with a full buffer, the buffer moves into ir_out with ir_valid=1 in the same edge, so there is no bubble.
  - br_load flushes both IR and buffer. An in-flight prefetch is discarded using the pending-branch rule.
  - A timeout during prefetch sets fetch_err and goes to ERR.
- Undefined: no buffer. Behaviour is exactly as above, with one bubble of at least 2 cycles between instructions.

Test Plan:
1. Reset with RESET_PC=0; mem returns 32'h0555E52B with mem_moc 1 cycle after mem_mfa -> mem_addr=0; ir_out=32'h0555E52B, ir_valid=1, pc_out=4; ack gives mem_mfa at addr 4 the next cycle.
2. Four sequential fetches, words 32'h052D56AD, 32'h04154275, 32'hE1D45004, 32'h01C000D0, ack 2 cycles after each valid -> ir_out sequence matches in order; pc_out ends at 16; ir_out never changes while ir_valid=1 without ack.
3. br_load with target 32'h0000_0103 in HOLD -> ir_valid drops next cycle; next mem_addr=32'h100; pc_out=32'h104 after the fetch.
4. br_load target 32'h200 during WAIT, mem_moc 3 cycles later with 32'hDEADBEEF -> ir_valid stays 0; the next request is at addr 32'h200; DEADBEEF never appears on ir_out.
5. mem_moc never asserted, TIMEOUT=15 -> fetch_err=1 on the 15th WAIT cycle; mem_mfa=0; br_load/fetch_en ignored; rst_n low clears everything.
6. Start with pc=32'hFFFF_FFFC via branch, one fetch -> pc_out wraps to 0. Also assert rst_n low mid-WAIT -> mem_mfa=0 without a clock edge.
